// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared access-size and FSM state types for the memory arbiter
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte enables, store replication, load extraction/extension, misalign detect
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = 32'h0;
    misalign  = 1'b0;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be        = 4'b0011 << addr_lo;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{sign_ext & half_sel[15]}}, half_sel};
        misalign  = addr_lo[0];
      end
      SZ_WORD: begin
        be        = 4'b1111;
        rdata_ext = rdata;
        misalign  = (addr_lo != 2'b00);
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - instruction/data port arbiter onto one byte-enabled RAM
// Define ROUND_ROBIN_EN for alternating grants on contention; default is data-port priority.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_resp_valid,
  output logic [31:0]       i_rdata,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_signed,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_resp_valid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_e            state_q, state_d;
  logic              gnt_d_q, gnt_d_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              we_q, we_d;
  logic              sign_q, sign_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              i_resp_valid_q, i_resp_valid_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic              d_resp_valid_q, d_resp_valid_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              d_err_q, d_err_d;

  logic              idle, issue, pick_d, grant_d, grant_i;
  logic [1:0]        al_addr_lo, al_size;
  logic [31:0]       al_wdata, al_wdata_rep, al_rdata_ext;
  logic [3:0]        al_be;
  logic              al_misalign;

  assign idle  = (state_q == IDLE);
  assign issue = (state_q == ISSUE);

`ifdef ROUND_ROBIN_EN
  logic both, rr_q, rr_d;

  // rr_q set means the instruction port wins the next contended cycle
  assign both   = i_req_valid & d_req_valid;
  assign pick_d = d_req_valid & ~(both & rr_q);

  always_comb begin
    rr_d = rr_q;
    if ((grant_d | grant_i) & both) rr_d = grant_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end
`else
  assign pick_d = d_req_valid;
`endif

  assign grant_d = rst_n & idle & pick_d;
  assign grant_i = rst_n & idle & i_req_valid & ~pick_d;

  // In IDLE the aligner checks the live data request; afterwards it works on the held fields
  assign al_addr_lo = idle ? d_addr[1:0] : (gnt_d_q ? addr_q[1:0] : 2'b00);
  assign al_size    = idle ? d_size : size_q;
  assign al_wdata   = idle ? d_wdata : wdata_q;

  mem_lane_align u_lane_align (
    .addr_lo   (al_addr_lo),
    .size      (al_size),
    .sign_ext  (sign_q),
    .wdata     (al_wdata),
    .rdata     (ram_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata_rep),
    .rdata_ext (al_rdata_ext),
    .misalign  (al_misalign)
  );

  assign i_req_ready  = grant_i;
  assign d_req_ready  = grant_d;
  assign ram_we       = issue & gnt_d_q & we_q;
  assign ram_be       = issue ? al_be : 4'b0000;
  assign ram_addr     = issue ? {2'b00, addr_q[ADDR_W-1:2]} : '0;
  assign ram_wdata    = issue ? al_wdata_rep : 32'h0;
  assign i_resp_valid = i_resp_valid_q;
  assign i_rdata      = i_rdata_q;
  assign d_resp_valid = d_resp_valid_q;
  assign d_rdata      = d_rdata_q;
  assign d_err        = d_err_q;

  always_comb begin
    state_d        = state_q;
    gnt_d_d        = gnt_d_q;
    addr_d         = addr_q;
    size_d         = size_q;
    we_d           = we_q;
    sign_d         = sign_q;
    wdata_d        = wdata_q;
    i_resp_valid_d = 1'b0;
    i_rdata_d      = 32'h0;
    d_resp_valid_d = 1'b0;
    d_rdata_d      = 32'h0;
    d_err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_d | grant_i) begin
          gnt_d_d = grant_d;
          addr_d  = grant_d ? d_addr : i_addr;
          size_d  = grant_d ? d_size : SZ_WORD;
          we_d    = grant_d & d_we;
          sign_d  = grant_d & d_signed;
          wdata_d = grant_d ? d_wdata : 32'h0;
          // Bad data accesses skip the RAM and answer with an error straight away
          if (grant_d & al_misalign) begin
            d_resp_valid_d = 1'b1;
            d_err_d        = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        state_d = IDLE;
        if (gnt_d_q) begin
          d_resp_valid_d = 1'b1;
          d_rdata_d      = we_q ? 32'h0 : al_rdata_ext;
        end else begin
          i_resp_valid_d = 1'b1;
          i_rdata_d      = al_rdata_ext;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      gnt_d_q        <= 1'b0;
      addr_q         <= '0;
      size_q         <= 2'b00;
      we_q           <= 1'b0;
      sign_q         <= 1'b0;
      wdata_q        <= 32'h0;
      i_resp_valid_q <= 1'b0;
      i_rdata_q      <= 32'h0;
      d_resp_valid_q <= 1'b0;
      d_rdata_q      <= 32'h0;
      d_err_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      gnt_d_q        <= gnt_d_d;
      addr_q         <= addr_d;
      size_q         <= size_d;
      we_q           <= we_d;
      sign_q         <= sign_d;
      wdata_q        <= wdata_d;
      i_resp_valid_q <= i_resp_valid_d;
      i_rdata_q      <= i_rdata_d;
      d_resp_valid_q <= d_resp_valid_d;
      d_rdata_q      <= d_rdata_d;
      d_err_q        <= d_err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a byte-level memory model
module tb_mem_arbiter;

  localparam int NMAX = 2048;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_req_ready, i_resp_valid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req_valid, d_req_ready, d_we, d_signed, d_resp_valid, d_err;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_resp_valid(i_resp_valid), .i_rdata(i_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
    .d_size(d_size), .d_signed(d_signed), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_resp_valid(d_resp_valid), .d_rdata(d_rdata), .d_err(d_err),
    .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int w);
    return 32'(w * 32'h0100_0193) ^ 32'hA5C3_0F1E;
  endfunction

  // Environment RAM: 64 words, one-cycle read latency, byte-enabled writes
  logic [31:0] ram_mem [0:63];
  logic [31:0] wt;
  logic        mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int w = 0; w < 64; w++) ram_mem[w] <= pat(w);
    end else begin
      ram_rdata <= ram_mem[ram_addr[5:0]];
      if (ram_we) begin
        wt = ram_mem[ram_addr[5:0]];
        for (int k = 0; k < 4; k++) if (ram_be[k]) wt[8*k +: 8] = ram_wdata[8*k +: 8];
        ram_mem[ram_addr[5:0]] <= wt;
      end
    end
  end

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        iv;
    logic        dv;
    logic        err;
    logic [31:0] ird;
    logic [31:0] drd;
    logic        st;
    logic [7:0]  st_a;
    logic [2:0]  st_n;
    logic [31:0] st_d;
  } exp_t;

  exp_t       ex [0:NMAX+7];
  logic [7:0] mem_b [0:255];
  int         cyc, next_free;
  bit         last_contest_d;
  int         n_checks = 0, n_errors = 0;

  logic        s_iv, s_dv, s_we, s_signed;
  logic [1:0]  s_size;
  logic [31:0] s_ia, s_da, s_wd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    next_free      = cyc;
    last_contest_d = 1'b0;
    for (int i = cyc; i < cyc + 8; i++) ex[i] = '0;
  endtask

  // One clock: check this cycle's outputs, present stimulus, check grants, schedule expectations
  task automatic step(output bit gi, output bit gd);
    exp_t        e;
    bit          misal;
    int          n, base;
    logic [7:0]  a;
    logic [31:0] v;
    e = ex[cyc];
    check("ram_we", ram_we, e.we);
    check("ram_be", ram_be, e.be);
    if (e.be != 4'b0) check("ram_addr", ram_addr, e.addr);
    if (e.we) check("ram_wdata", ram_wdata, e.wdata);
    check("i_resp_valid", i_resp_valid, e.iv);
    check("d_resp_valid", d_resp_valid, e.dv);
    check("d_err", d_err, e.err);
    if (e.iv) check("i_rdata", i_rdata, e.ird);
    if (e.dv) check("d_rdata", d_rdata, e.drd);

    i_req_valid = s_iv; i_addr = s_ia;
    d_req_valid = s_dv; d_we = s_we; d_size = s_size; d_signed = s_signed;
    d_addr = s_da; d_wdata = s_wd;
    #1;
    gi = 1'b0; gd = 1'b0;
    if (cyc >= next_free) begin
      if (s_dv && s_iv) begin
`ifdef ROUND_ROBIN_EN
        gd = !last_contest_d;
        gi = last_contest_d;
        last_contest_d = gd;
`else
        gd = 1'b1;
`endif
      end else begin
        gd = s_dv;
        gi = s_iv;
      end
    end
    check("i_req_ready", i_req_ready, gi);
    check("d_req_ready", d_req_ready, gd);

    if (gd) begin
      a = s_da[7:0];
      n = (s_size == 2'd0) ? 1 : (s_size == 2'd1) ? 2 : 4;
      misal = (s_size == 2'd3) || (s_size == 2'd1 && a[0]) || (s_size == 2'd2 && a[1:0] != 2'b00);
      if (misal) begin
        ex[cyc+1].dv  = 1'b1;
        ex[cyc+1].err = 1'b1;
        ex[cyc+1].drd = 32'h0;
        next_free = cyc + 1;
      end else begin
        base = int'(a) & 32'hFC;
        for (int k = 0; k < 4; k++) begin
          ex[cyc+1].be[k] = (base + k >= int'(a)) && (base + k < int'(a) + n);
          ex[cyc+1].wdata[8*k +: 8] = s_wd[8*(k % n) +: 8];
        end
        ex[cyc+1].addr = s_da >> 2;
        ex[cyc+1].we   = s_we;
        ex[cyc+3].dv   = 1'b1;
        if (s_we) begin
          ex[cyc+1].st   = 1'b1;
          ex[cyc+1].st_a = a;
          ex[cyc+1].st_n = 3'(n);
          ex[cyc+1].st_d = s_wd;
          ex[cyc+3].drd  = 32'h0;
        end else begin
          v = 32'h0;
          for (int j = 0; j < n; j++) v[8*j +: 8] = mem_b[int'(a) + j];
          if (s_signed && v[8*n-1]) for (int j = 8*n; j < 32; j++) v[j] = 1'b1;
          ex[cyc+3].drd = v;
        end
        next_free = cyc + 3;
      end
    end
    if (gi) begin
      base = int'(s_ia[7:0]) & 32'hFC;
      v = 32'h0;
      for (int j = 0; j < 4; j++) v[8*j +: 8] = mem_b[base + j];
      ex[cyc+1].be   = 4'hF;
      ex[cyc+1].addr = s_ia >> 2;
      ex[cyc+3].iv   = 1'b1;
      ex[cyc+3].ird  = v;
      next_free = cyc + 3;
    end

    @(posedge clk);
    if (rst_n && ex[cyc].st) begin
      e = ex[cyc];
      for (int j = 0; j < int'(e.st_n); j++) mem_b[int'(e.st_a) + j] = e.st_d[8*j +: 8];
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit gi, gd;
    s_iv = 1'b0; s_dv = 1'b0;
    for (int t = 0; t < n; t++) step(gi, gd);
  endtask

  task automatic send();
    bit gi, gd, done;
    done = 1'b0;
    for (int t = 0; t < 20 && !done; t++) begin
      step(gi, gd);
      if (gi || gd) done = 1'b1;
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    s_iv = 1'b0; s_dv = 1'b0;
  endtask

  task automatic set_d(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd);
    s_dv = 1'b1; s_we = we; s_size = sz; s_signed = sg; s_da = ad; s_wd = wd;
  endtask

  initial begin
    bit          gi, gd;
    int          k;
    logic [3:0]  seq, exp_seq;
    logic [31:0] pw;

    rst_n = 1'b0; mem_init = 1'b1; cyc = 0;
    s_iv = 1'b1; s_dv = 1'b1; s_we = 1'b1; s_size = 2'd2; s_signed = 1'b0;
    s_ia = 32'h10; s_da = 32'h20; s_wd = 32'hDEAD_BEEF;
    i_req_valid = 1'b1; i_addr = s_ia; d_req_valid = 1'b1; d_we = 1'b1;
    d_size = 2'd2; d_signed = 1'b0; d_addr = s_da; d_wdata = s_wd;
    for (int w = 0; w < 64; w++) begin
      pw = pat(w);
      for (int j = 0; j < 4; j++) mem_b[4*w + j] = pw[8*j +: 8];
    end
    for (int i = 0; i < NMAX + 8; i++) ex[i] = '0;
    #2;
    check("rst_i_ready", i_req_ready, 1'b0);
    check("rst_d_ready", d_req_ready, 1'b0);
    check("rst_i_resp", i_resp_valid, 1'b0);
    check("rst_d_resp", d_resp_valid, 1'b0);
    check("rst_d_err", d_err, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_ram_be", ram_be, 4'b0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_i_rdata", i_rdata, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0; rst_n = 1'b1;
    s_iv = 1'b0; s_dv = 1'b0;
    model_reset();
    idle(2);

    // Byte store to the top lane
    set_d(1'b1, 2'd0, 1'b0, 32'h103, 32'h1234_56A5);
    send();
    check("st_byte_we", ram_we, 1'b1);
    check("st_byte_be", ram_be, 4'b1000);
    check("st_byte_wdata", ram_wdata, 32'hA5A5_A5A5);
    check("st_byte_addr", ram_addr, 32'h40);
    idle(4);

    // Signed halfword load three cycles after acceptance
    set_d(1'b1, 2'd2, 1'b0, 32'h100, 32'h8001_1234);
    send();
    idle(3);
    set_d(1'b0, 2'd1, 1'b1, 32'h102, 32'h0);
    send();
    idle(2);
    check("ld_half_valid", d_resp_valid, 1'b1);
    check("ld_half_data", d_rdata, 32'hFFFF_8001);
    idle(2);

    // Misaligned word load errors on the next cycle without touching the RAM
    set_d(1'b0, 2'd2, 1'b0, 32'h101, 32'h0);
    send();
    check("mis_valid", d_resp_valid, 1'b1);
    check("mis_err", d_err, 1'b1);
    check("mis_rdata", d_rdata, 32'h0);
    check("mis_ram_be", ram_be, 4'b0);
    idle(2);

    // Both ports held valid
    s_iv = 1'b1; s_ia = 32'h44;
    set_d(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    seq = 4'b0; k = 0;
    for (int t = 0; t < 12; t++) begin
      step(gi, gd);
      if (gi || gd) begin
        if (k < 4) seq[k] = gd;
        k++;
      end
    end
`ifdef ROUND_ROBIN_EN
    exp_seq = 4'b0101;
`else
    exp_seq = 4'b1111;
`endif
    check("arb_seq", seq, exp_seq);
    check("arb_grants", k, 32'd4);
    idle(4);

    // Reset while a store is in ISSUE
    set_d(1'b1, 2'd2, 1'b0, 32'h80, 32'hCAFE_F00D);
    send();
    check("rst_issue_we_before", ram_we, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_issue_we", ram_we, 1'b0);
    check("rst_issue_be", ram_be, 4'b0);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(5);
    set_d(1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
    send();
    idle(3);

    // Randomised traffic
    for (int t = 0; t < 1000; t++) begin
      s_iv     = ($urandom_range(0, 3) != 0);
      s_dv     = ($urandom_range(0, 3) != 0);
      s_ia     = $urandom_range(0, 255);
      s_da     = $urandom_range(0, 255);
      s_size   = 2'($urandom_range(0, 3));
      s_we     = 1'($urandom_range(0, 1));
      s_signed = 1'($urandom_range(0, 1));
      s_wd     = $urandom;
      step(gi, gd);
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, width of requester byte addresses and of ram_addr.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 i_req_valid  in  1  instruction-fetch request (word read only).
REQ-005 i_req_ready  out  1  instruction request accepted this cycle.
REQ-006 i_addr  in  ADDR_W  instruction byte address.
REQ-007 i_resp_valid  out  1  one-cycle pulse, i_rdata valid.
REQ-008 i_rdata  out  32  fetched word.
REQ-009 d_req_valid  in  1  data request.
REQ-010 d_req_ready  out  1  data request accepted this cycle.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-013 d_signed  in  1  load sign-extends when 1, zero-extends when 0.
REQ-014 d_addr  in  ADDR_W  data byte address.
REQ-015 d_wdata  in  32  store data, right-justified.
REQ-016 d_resp_valid  out  1  one-cycle pulse; load data or store acknowledge.
REQ-017 d_rdata  out  32  extended load data; 0 for stores.
REQ-018 d_err  out  1  qualifies d_resp_valid; misaligned or illegal-size access.
REQ-019 ram_we, ram_be[3:0], ram_addr[ADDR_W-1:0], ram_wdata[31:0]  out  drive the byte-enabled RAM; ram_addr is the word index {2'b00, addr[ADDR_W-1:2]}.
REQ-020 ram_rdata  in  32  RAM read word, valid the cycle after the address is presented.

Function
REQ-021 FSM states: IDLE, ISSUE, RESP; transitions IDLE->ISSUE on grant, ISSUE->RESP unconditionally, RESP->IDLE unconditionally.
REQ-022 In IDLE, a request is accepted only when no response is pending; the accepted requester's ready is high for exactly that cycle, and at most one ready is high per cycle.
REQ-023 Without ROUND_ROBIN_EN, the data port wins when both ports are valid in the same cycle.
REQ-024 Accepted request fields are registered; requester inputs are don't-care after acceptance.
REQ-025 In ISSUE, ram_addr, ram_be and ram_wdata are driven from the registered fields, and ram_we=d_we for data stores; ram_we=0 in every other state.
REQ-026 be: byte=4'b0001<<addr[1:0]; half=4'b0011<<addr[1:0]; word=4'b1111; instruction=4'b1111.
REQ-027 Write data is replicated across lanes: byte={4{wdata[7:0]}}, half={2{wdata[15:0]}}, word unchanged.
REQ-028 In RESP, ram_rdata is lane-selected by addr[1:0], extended per d_signed, and returned with a resp_valid pulse to the granted port; load-to-response latency is 3 cycles from acceptance, and peak throughput is one access per 3 cycles.
REQ-029 Misaligned or illegal access (half with addr[0]=1, word with addr[1:0]!=0, or size=11) is accepted, but the RAM is never driven (ram_we=0, ram_be=0); d_resp_valid=1, d_err=1 and d_rdata=0 follow in the next cycle, and the FSM returns to IDLE.
REQ-030 Instruction addresses with addr[1:0]!=0 are fetched word-aligned (low bits ignored); there is no error path on the instruction port.
REQ-031 resp_valid has no backpressure; requesters must accept the response pulse.

Reset
REQ-032 rst_n low forces IDLE immediately, clears the grant and round-robin pointer, and drives all ready, resp_valid, d_err and ram_we outputs to 0 and all data outputs to 0.
REQ-033 Reset during ISSUE or RESP aborts the access; no response is generated after reset is released.

Configuration
REQ-034 When ROUND_ROBIN_EN is defined, simultaneous requests alternate grants: the port not granted last wins, and the pointer updates only on a grant with both ports valid; when it is undefined, the fixed priority of REQ-023 applies.

Structure
REQ-035 Shared package mem_pkg holds the size_e enumeration (SZ_BYTE, SZ_HALF, SZ_WORD) and the state_e enumeration (IDLE, ISSUE, RESP).
REQ-036 A combinational sub-module mem_lane_align computes be, replicated write data, extracted and extended load data, and the misalign flag; it is instantiated once.

Verification
REQ-037 Store byte 0xA5 at d_addr=0x103 -> ram_be=1000, ram_wdata=0xA5A5A5A5, ram_addr=0x40, ram_we=1 for exactly one cycle.
REQ-038 Signed halfword load at 0x102 with ram_rdata=0x8001_1234 -> d_rdata=0xFFFF8001, d_resp_valid 3 cycles after acceptance.
REQ-039 Word load at 0x101 -> d_err=1, d_rdata=0, no RAM cycle, response the cycle after acceptance.
REQ-040 Both ports continuously valid -> without ROUND_ROBIN_EN only the data port is served; with ROUND_ROBIN_EN grants alternate D,I,D,I.
REQ-041 Assert rst_n low in ISSUE of a store -> ram_we drops immediately, no resp_valid follows, next grant works normally.
